// File: rtl/upc_pkg.sv
// Shared types and named codes for the UPC switch conditioner and the 7-segment decoder.
package upc_pkg;

  localparam int unsigned UPC_W = 3;

  typedef enum logic [1:0] {
    STABLE = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } upc_cond_state_t;

  localparam logic [UPC_W-1:0] CODE_SHOES = 3'b000;
  localparam logic [UPC_W-1:0] CODE_001   = 3'b001;
  localparam logic [UPC_W-1:0] CODE_010   = 3'b010;
  localparam logic [UPC_W-1:0] CODE_011   = 3'b011;
  localparam logic [UPC_W-1:0] CODE_100   = 3'b100;
  localparam logic [UPC_W-1:0] CODE_101   = 3'b101;
  localparam logic [UPC_W-1:0] CODE_110   = 3'b110;
  localparam logic [UPC_W-1:0] CODE_111   = 3'b111;

endpackage

// File: rtl/sync_2ff.sv
// W-bit two-flop synchroniser for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
  parameter int unsigned    W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/upc_switch_conditioner.sv
// Synchronises and debounces the {U,P,C} slide switches as one code, with a KEY-driven
// lock that freezes the presented code until the key is pressed again.
module upc_switch_conditioner
  import upc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [UPC_W-1:0] sw_raw,
  input  logic             key_lock_n,
  output logic [UPC_W-1:0] upc,
  output logic             upc_valid,
  output logic             upc_change,
  output logic             locked
);

  localparam int unsigned      CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [UPC_W-1:0] sw_s;
  logic             key_s;
  logic             key_prev_q;
  logic             lock_tog_q;

  upc_cond_state_t  state_q,  state_d;
  logic [UPC_W-1:0] cand_q,   cand_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [UPC_W-1:0] upc_q,    upc_d;
  logic             valid_q,  valid_d;
  logic             change_q, change_d;
  logic             locked_q, locked_d;
  logic             lock_req_c;

  sync_2ff #(.W(UPC_W), .RST_VAL('0)) u_sync_sw (
    .clk   (clk),
    .reset (reset),
    .d_i   (sw_raw),
    .q_o   (sw_s)
  );

  // Key idles high (released), so its synchroniser resets to 1.
  sync_2ff #(.W(1), .RST_VAL(1'b1)) u_sync_key (
    .clk   (clk),
    .reset (reset),
    .d_i   (key_lock_n),
    .q_o   (key_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_prev_q <= 1'b1;
      lock_tog_q <= 1'b0;
      state_q    <= SETTLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      upc_q      <= '0;
      valid_q    <= 1'b0;
      change_q   <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      key_prev_q <= key_s;
      lock_tog_q <= key_prev_q & ~key_s;
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      upc_q      <= upc_d;
      valid_q    <= valid_d;
      change_q   <= change_d;
      locked_q   <= locked_d;
    end
  end

  // A lock request only counts once a code has been accepted; it beats a same-cycle acceptance.
  assign lock_req_c = lock_tog_q & valid_q;

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    upc_d    = upc_q;
    valid_d  = valid_q;
    change_d = 1'b0;
    locked_d = locked_q;
    unique case (state_q)
      STABLE: begin
        if (lock_req_c) begin
          state_d  = LOCKED;
          locked_d = 1'b1;
        end else if (sw_s != upc_q) begin
          state_d = SETTLE;
          cand_d  = sw_s;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (lock_req_c) begin
          state_d  = LOCKED;
          locked_d = 1'b1;
          cnt_d    = '0;
        end else if (sw_s != cand_q) begin
          cand_d = sw_s;
          cnt_d  = '0;
          if (valid_q && (sw_s == upc_q)) begin
            state_d = STABLE;
          end
        end else if (cnt_q == CNT_MAX) begin
          upc_d    = cand_q;
          valid_d  = 1'b1;
          change_d = (cand_q != upc_q) || !valid_q;
          state_d  = STABLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOCKED: begin
        // Unlock always re-debounces, even when the switches still match the held code.
        if (lock_tog_q) begin
          state_d  = SETTLE;
          cand_d   = sw_s;
          cnt_d    = '0;
          locked_d = 1'b0;
        end
      end
      default: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign upc        = upc_q;
  assign upc_valid  = valid_q;
  assign upc_change = change_q;
  assign locked     = locked_q;

endmodule
